// File: rtl/byte_packetizer_if.sv
// Byte stream handshake bundle: upstream valid/ready input and
// downstream valid/ready output with end-of-packet marker.
interface byte_packetizer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/byte_packetizer.sv
// Buffers input bytes in a FIFO and emits PKT_LEN-byte packets,
// each closed by a two's-complement checksum byte.
module byte_packetizer #(
   parameter int PKT_LEN    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   byte_packetizer_if.slave   bus,
   output logic [15:0]        pkt_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   FULL     = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [7:0]    LAST_IDX = 8'(PKT_LEN - 1);

   typedef enum logic {PAYLOAD, CHECK} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   state_t        state;
   logic [7:0]    sum;
   logic [7:0]    idx;
   logic [7:0]    head;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          last_q;
   logic          push;
   logic          pop;
   logic          load;
   logic          fire;

   // in_ready depends only on registered occupancy: no bypass when full
   assign bus.in_ready  = rst_n && (count != FULL);
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_last  = last_q;

   assign head = mem[rd_ptr];
   assign push = bus.in_valid && bus.in_ready;
   assign fire = valid_q && bus.out_ready;
   assign load = !valid_q || bus.out_ready;
   assign pop  = load && (state == PAYLOAD) && (count != '0);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         state     <= PAYLOAD;
         sum       <= 8'd0;
         idx       <= 8'd0;
         data_q    <= 8'd0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         pkt_count <= 16'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (fire && last_q) pkt_count <= pkt_count + 16'd1;
         if (load) begin
            unique case (state)
               PAYLOAD: begin
                  valid_q <= pop;
                  if (pop) begin
                     data_q <= head;
                     last_q <= 1'b0;
                     sum    <= sum + head;
                     idx    <= idx + 8'd1;
                     if (idx == LAST_IDX) state <= CHECK;
                  end
               end
               CHECK: begin
                  valid_q <= 1'b1;
                  data_q  <= 8'd0 - sum;
                  last_q  <= 1'b1;
                  sum     <= 8'd0;
                  idx     <= 8'd0;
                  state   <= PAYLOAD;
               end
               default: state <= PAYLOAD;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_byte_packetizer.sv
// Scoreboard bench for byte_packetizer: accepted bytes feed an
// expected-stream model, observed output handshakes are compared.
module tb_byte_packetizer;
   localparam int PKT_LEN    = 4;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] pkt_count;

   byte_packetizer_if bus();

   byte_packetizer #(
      .PKT_LEN    (PKT_LEN),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .pkt_count (pkt_count)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         acc_cnt = 0;
   logic [7:0] msum = 8'd0;
   int         midx = 0;

   // model: expected stream is built from bytes as they are accepted
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid && bus.in_ready) begin
            acc_cnt++;
            exp_q.push_back({1'b0, bus.in_data});
            msum = msum + bus.in_data;
            midx++;
            if (midx == PKT_LEN) begin
               exp_q.push_back({1'b1, 8'(8'd0 - msum)});
               msum = 8'd0;
               midx = 0;
            end
         end
         if (bus.out_valid && bus.out_ready)
            obs_q.push_back({bus.out_last, bus.out_data});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      exp_q.delete();
      obs_q.delete();
      msum = 8'd0;
      midx = 0;
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (!bus.in_ready && t < 200) begin
         tick();
         t++;
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_obs(input int n, output bit ok);
      int t = 0;
      while (obs_q.size() < n && t < 500) begin
         tick();
         t++;
      end
      ok = (obs_q.size() >= n);
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, bus.out_last, bus.out_data, pkt_count} !== 26'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b l=%b d=%h cnt=%h want all 0",
                  bus.out_valid, bus.out_last, bus.out_data, pkt_count);
      end
      rst_n = 1'b1;
      clear_model();
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      logic [8:0] o, e;
      bit ok;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h01;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early got out_valid=%b want 0", bus.out_valid);
      end
      bus.in_data = 8'h02;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
         errors++;
         $display("FAIL latency_first got v=%b d=%h want v=1 d=01",
                  bus.out_valid, bus.out_data);
      end
      bus.in_data = 8'h03;
      tick();
      bus.in_data = 8'h04;
      tick();
      bus.in_valid = 1'b0;
      wait_obs(5, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL basic_timeout got %0d bytes want 5", obs_q.size());
      end
      for (int k = 0; k < 5 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL basic_byte%0d got %h want %h", k, o, e);
         end
         if (k == 4) begin
            checks++;
            if (o !== 9'h1F6) begin
               errors++;
               $display("FAIL basic_checksum got %h want 1f6", o);
            end
         end
      end
      tick();
      checks++;
      if (pkt_count !== 16'd1) begin
         errors++;
         $display("FAIL basic_pkt_count got %0d want 1", pkt_count);
      end
   endtask

   task automatic test_checksum_wrap();
      logic [8:0] o, e;
      bit ok;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(8'hFF);
      for (int i = 0; i < 4; i++) send(8'h00);
      wait_obs(10, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL wrap_timeout got %0d bytes want 10", obs_q.size());
      end
      for (int k = 0; k < 10 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrap_byte%0d got %h want %h", k, o, e);
         end
         if (k == 4 || k == 9) begin
            checks++;
            if (o !== ((k == 4) ? 9'h104 : 9'h100)) begin
               errors++;
               $display("FAIL wrap_checksum%0d got %h want %h", k, o,
                        (k == 4) ? 9'h104 : 9'h100);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] o, e;
      bit ok;
      int base;
      base = acc_cnt;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_data = 8'(8'h10 + (acc_cnt - base));
         tick();
         if (i >= 2) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10) begin
               errors++;
               $display("FAIL stall_hold%0d got v=%b d=%h want v=1 d=10",
                        i, bus.out_valid, bus.out_data);
            end
         end
      end
      checks++;
      if (acc_cnt - base !== 5) begin
         errors++;
         $display("FAIL stall_accepts got %0d want 5", acc_cnt - base);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_in_ready got %b want 0", bus.in_ready);
      end
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if (acc_cnt - base !== 5) begin
         errors++;
         $display("FAIL full_pop_accept got %0d want 5", acc_cnt - base);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_pop_ready got %b want 1", bus.in_ready);
      end
      bus.in_valid = 1'b0;
      send(8'h15);
      send(8'h16);
      send(8'h17);
      wait_obs(10, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL bp_timeout got %0d bytes want 10", obs_q.size());
      end
      for (int k = 0; k < 10 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bp_byte%0d got %h want %h", k, o, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [8:0] o, e;
      bit ok;
      bus.out_ready = 1'b1;
      send(8'h21);
      send(8'h22);
      wait_obs(2, ok);
      for (int k = 0; k < 2 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL mid_byte%0d got %h want %h", k, o, e);
         end
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, pkt_count}
          !== 27'd0) begin
         errors++;
         $display("FAIL mid_reset got r=%b v=%b l=%b d=%h cnt=%h want all 0",
                  bus.in_ready, bus.out_valid, bus.out_last, bus.out_data,
                  pkt_count);
      end
      rst_n = 1'b1;
      clear_model();
      for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
      wait_obs(5, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL fresh_timeout got %0d bytes want 5", obs_q.size());
      end
      for (int k = 0; k < 5 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL fresh_byte%0d got %h want %h", k, o, e);
         end
      end
      tick();
      checks++;
      if (pkt_count !== 16'd1) begin
         errors++;
         $display("FAIL fresh_pkt_count got %0d want 1", pkt_count);
      end
   endtask

   task automatic test_random();
      logic [8:0] o, e;
      logic [7:0] psum;
      bit ok;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      clear_model();
      fork
         begin
            for (int i = 0; i < 3 * PKT_LEN; i++) begin
               repeat ($urandom_range(0, 2)) tick();
               send(8'($urandom));
            end
         end
         begin
            for (int t = 0; t < 3000 && obs_q.size() < 15; t++) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               tick();
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_obs(15, ok);
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL rand_timeout got %0d bytes want 15", obs_q.size());
      end
      psum = 8'd0;
      for (int k = 0; k < 15 && obs_q.size() > 0; k++) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rand_byte%0d got %h want %h", k, o, e);
         end
         psum = psum + o[7:0];
         if (o[8]) begin
            checks++;
            if (psum !== 8'd0) begin
               errors++;
               $display("FAIL rand_pkt_sum%0d got %h want 00", k, psum);
            end
            psum = 8'd0;
         end
      end
      tick();
      tick();
      checks++;
      if (pkt_count !== 16'd3) begin
         errors++;
         $display("FAIL rand_pkt_count got %0d want 3", pkt_count);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_checksum_wrap();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
